// File: rtl/clk_gen_param.sv
// Divides clk_in into sys/sample/symbol clock enables with a symbol phase count and
// boundary-aligned timing advance/retard. Define CLK_GEN_CLK_OUT_EN for square-wave clock outputs.
module clk_gen_param #(
    parameter int SYS_DIV = 2,
    parameter int SAM_DIV = 4,
    parameter int SPS     = 4,
    parameter int PHASE_W = 4
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               adj_req,
    input  logic               adj_dir,
    output logic               adj_busy,
    output logic               adj_ack,
    output logic               sys_clk_ena,
    output logic               sam_clk_ena,
    output logic               sym_clk_ena,
    output logic [PHASE_W-1:0] clk_phase,
    output logic               sys_clk,
    output logic               sam_clk,
    output logic               sym_clk
);

    localparam int N     = SAM_DIV * SPS;
    localparam int DIV_W = (SYS_DIV > 2) ? $clog2(SYS_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } adj_state_t;

    adj_state_t         state_reg, state_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               hold_reg, hold_next;
    logic               dir_reg, dir_next;
    logic               sam_point;
    logic               sym_point;

    assign sys_clk_ena = (div_cnt_reg == DIV_W'(SYS_DIV - 1));
    assign sam_point   = ((int'(phase_reg) % SAM_DIV) == (SAM_DIV - 1));
    assign sym_point   = (phase_reg == PHASE_W'(N - 1));
    assign sam_clk_ena = sys_clk_ena & sam_point;
    assign sym_clk_ena = sys_clk_ena & sym_point;
    assign adj_busy    = (state_reg == PEND);
    assign clk_phase   = phase_reg;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            phase_reg   <= '0;
            hold_reg    <= 1'b0;
            dir_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            phase_reg   <= phase_next;
            hold_reg    <= hold_next;
            dir_reg     <= dir_next;
        end
    end

    // Adjust FSM: a request accepted on a symbol boundary waits for the next one.
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        adj_ack    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (adj_req) begin
                    state_next = PEND;
                    dir_next   = adj_dir;
                end
            end
            PEND: begin
                if (sym_clk_ena) begin
                    adj_ack    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Advance skips phase 0; retard holds phase 0 for one extra sys tick.
    always_comb begin
        div_cnt_next = sys_clk_ena ? '0 : div_cnt_reg + DIV_W'(1);
        phase_next   = phase_reg;
        hold_next    = hold_reg;
        if (sys_clk_ena) begin
            if (adj_ack) begin
                phase_next = dir_reg ? PHASE_W'(1) : '0;
                hold_next  = ~dir_reg;
            end else if (hold_reg) begin
                hold_next  = 1'b0;
            end else if (sym_point) begin
                phase_next = '0;
            end else begin
                phase_next = phase_reg + PHASE_W'(1);
            end
        end
    end

`ifdef CLK_GEN_CLK_OUT_EN
    logic [2:0] clk_out_reg;
    logic [2:0] clk_out_next;

    assign clk_out_next = {phase_reg >= PHASE_W'(N / 2),
                           (int'(phase_reg) % SAM_DIV) >= (SAM_DIV / 2),
                           div_cnt_reg >= DIV_W'(SYS_DIV / 2)};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_out_reg <= '0;
        end else begin
            clk_out_reg <= clk_out_next;
        end
    end

    assign sym_clk = clk_out_reg[2];
    assign sam_clk = clk_out_reg[1];
    assign sys_clk = clk_out_reg[0];
`else
    assign sym_clk = 1'b0;
    assign sam_clk = 1'b0;
    assign sys_clk = 1'b0;
`endif

endmodule
